// File: rtl/router_pkg.sv
// Shared definitions for the mesh router input port.
// Contents: flit type codes, output port indices, VC state encoding and the
// XY route function used on head flits.
package router_pkg;

   // Flit type field, carried in the two MSBs of every flit
   localparam logic [1:0] FT_BODY   = 2'b00;
   localparam logic [1:0] FT_HEAD   = 2'b01;
   localparam logic [1:0] FT_TAIL   = 2'b10;
   localparam logic [1:0] FT_SINGLE = 2'b11;

   // Router output ports, fixed order
   localparam int unsigned N_PORTS = 5;
   localparam int unsigned P_LOCAL = 0;
   localparam int unsigned P_EAST  = 1;
   localparam int unsigned P_WEST  = 2;
   localparam int unsigned P_NORTH = 3;
   localparam int unsigned P_SOUTH = 4;

   // Coordinates are zero-extended to this width before comparison
   localparam int unsigned COORD_W = 16;

   // Per-VC packet state
   localparam logic [0:0] VC_IDLE   = 1'b0;
   localparam logic [0:0] VC_ACTIVE = 1'b1;

   // Dimension-ordered route: resolve X first, then Y, else deliver locally
   function automatic logic [N_PORTS-1:0] xy_route(
      input logic [COORD_W-1:0] dst_x,
      input logic [COORD_W-1:0] dst_y,
      input logic [COORD_W-1:0] my_x,
      input logic [COORD_W-1:0] my_y
   );
      logic [N_PORTS-1:0] r;
      r = '0;
      if (dst_x > my_x)      r[P_EAST]  = 1'b1;
      else if (dst_x < my_x) r[P_WEST]  = 1'b1;
      else if (dst_y > my_y) r[P_SOUTH] = 1'b1;
      else if (dst_y < my_y) r[P_NORTH] = 1'b1;
      else                   r[P_LOCAL] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Single-VC flit buffer.
// Ports: push/din write, pop reads the front (dout is the current front,
// valid while !empty), empty/full status. A push on a full FIFO is only
// accepted when a pop happens in the same cycle; otherwise it is dropped.
module router_vc_fifo #(
   parameter int unsigned DATA_W = 35,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Storage needs no reset; empty gates its visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/router_vc_input_unit.sv
// Router input port: per-VC flit buffers, XY route computation on head
// flits, per-VC packet lock and credit return upstream.
// Ports: idata/ivalid/ivch incoming flits; oack credit pulses; olck packet
// lock per VC; req/req_port/fdata switch requests; grant allocator pops;
// ovf_err/proto_err sticky error flags.
module router_vc_input_unit
   import router_pkg::*;
#(
   parameter int unsigned DATA_W    = 35,
   parameter int unsigned NUM_VC    = 2,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned XPOS_W    = 2,
   parameter int unsigned YPOS_W    = 2,
   parameter int unsigned NUM_PORTS = 5,
   localparam int unsigned VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [XPOS_W-1:0]             my_xpos,
   input  logic [YPOS_W-1:0]             my_ypos,
   input  logic [DATA_W-1:0]             idata,
   input  logic                          ivalid,
   input  logic [VC_W-1:0]               ivch,
   output logic [NUM_VC-1:0]             oack,
   output logic [NUM_VC-1:0]             olck,
   output logic [NUM_VC-1:0]             req,
   output logic [NUM_VC*NUM_PORTS-1:0]   req_port,
   output logic [NUM_VC*DATA_W-1:0]      fdata,
   input  logic [NUM_VC-1:0]             grant,
   output logic                          ovf_err,
   output logic                          proto_err
);

   logic [NUM_VC-1:0] ovf_set;
   logic [NUM_VC-1:0] proto_set;

   for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      logic                 push;
      logic                 pop_c;
      logic                 auto_pop;
      logic                 req_c;
      logic                 empty;
      logic                 full;
      logic [DATA_W-1:0]    dout;
      logic [1:0]           ftype;
      logic                 is_head;
      logic [NUM_PORTS-1:0] route_c;
      logic [NUM_PORTS-1:0] port_c;
      logic [0:0]           state_q;
      logic [0:0]           state_d;
      logic [NUM_PORTS-1:0] route_q;
      logic [NUM_PORTS-1:0] route_d;

      assign push    = ivalid && (ivch == VC_W'(v));
      assign ftype   = dout[DATA_W-1 -: 2];
      assign is_head = (ftype == FT_HEAD) || (ftype == FT_SINGLE);
      assign route_c = NUM_PORTS'(xy_route(COORD_W'(dout[XPOS_W-1:0]),
                                           COORD_W'(dout[XPOS_W+YPOS_W-1:XPOS_W]),
                                           COORD_W'(my_xpos),
                                           COORD_W'(my_ypos)));

      router_vc_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push),
         .pop   (pop_c),
         .din   (idata),
         .dout  (dout),
         .empty (empty),
         .full  (full)
      );

      // Packet FSM: IDLE routes head flits, ACTIVE forwards on the latched route
      always_comb begin
         state_d  = state_q;
         route_d  = route_q;
         req_c    = 1'b0;
         auto_pop = 1'b0;
         port_c   = '0;
         case (state_q)
            VC_IDLE: begin
               if (!empty) begin
                  if (is_head) begin
                     req_c  = 1'b1;
                     port_c = route_c;
                     if (grant[v] && (ftype == FT_HEAD)) begin
                        state_d = VC_ACTIVE;
                        route_d = route_c;
                     end
                  end else begin
                     // Orphan body/tail: discard it so the VC cannot wedge
                     auto_pop = 1'b1;
                  end
               end
            end
            VC_ACTIVE: begin
               req_c  = !empty;
               port_c = route_q;
               if (grant[v] && !empty && (ftype == FT_TAIL)) state_d = VC_IDLE;
            end
            default: state_d = VC_IDLE;
         endcase
      end

      assign pop_c = (grant[v] && req_c) || auto_pop;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= VC_IDLE;
            route_q <= '0;
         end else begin
            state_q <= state_d;
            route_q <= route_d;
         end
      end

      assign oack[v]      = pop_c;
      assign req[v]       = req_c;
      assign olck[v]      = (state_q == VC_ACTIVE);
      assign ovf_set[v]   = push && full && !pop_c;
      assign proto_set[v] = auto_pop;
      assign req_port[v*NUM_PORTS +: NUM_PORTS] = port_c;
      assign fdata[v*DATA_W +: DATA_W]          = empty ? '0 : dout;
   end

   // Sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_err   <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         ovf_err   <= ovf_err || (|ovf_set);
         proto_err <= proto_err || (|proto_set);
      end
   end

endmodule

// File: tb/tb_router_vc_input_unit.sv
// Directed bench for router_vc_input_unit with default parameters, tile (1,1).
module tb_router_vc_input_unit;

   localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  my_xpos = 2'd1;
   logic [1:0]  my_ypos = 2'd1;
   logic [34:0] idata;
   logic        ivalid;
   logic [0:0]  ivch;
   logic [1:0]  oack;
   logic [1:0]  olck;
   logic [1:0]  req;
   logic [9:0]  req_port;
   logic [69:0] fdata;
   logic [1:0]  grant;
   logic        ovf_err;
   logic        proto_err;

   int passed = 0;
   int total  = 0;

   router_vc_input_unit dut (
      .clk       (clk),
      .rst       (rst),
      .my_xpos   (my_xpos),
      .my_ypos   (my_ypos),
      .idata     (idata),
      .ivalid    (ivalid),
      .ivch      (ivch),
      .oack      (oack),
      .olck      (olck),
      .req       (req),
      .req_port  (req_port),
      .fdata     (fdata),
      .grant     (grant),
      .ovf_err   (ovf_err),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   function automatic logic [34:0] mk(input logic [1:0] t, input logic [1:0] x,
                                      input logic [1:0] y, input int pl);
      return {t, 29'(pl), y, x};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   // Apply inputs just after the falling edge, then let combinational outputs settle
   task automatic drive(input logic v, input logic ch, input logic [34:0] d, input logic [1:0] g);
      ivalid = v;
      ivch   = ch;
      idata  = d;
      grant  = g;
      #1;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   logic [34:0] h0, b0, t0, h1, b1, t1, s [6];
   logic [1:0]  t2x [4];
   logic [1:0]  t2y [4];
   logic [4:0]  t2p [4];
   logic [1:0]  g5_olck [6];
   logic [1:0]  g5_req  [6];
   logic [4:0]  g5_p0   [6];
   logic [34:0] g5_fd   [6];
   logic [0:0]  ch5;
   logic [34:0] fd5;

   initial begin
      rst = 1'b1;
      ivalid = 1'b0; ivch = 1'b0; idata = '0; grant = '0;
      next_cycle(); next_cycle();
      #1;
      chk("reset_oack", 64'(oack), 64'd0);
      chk("reset_olck", 64'(olck), 64'd0);
      chk("reset_req", 64'(req), 64'd0);
      chk("reset_req_port", 64'(req_port), 64'd0);
      chk("reset_fdata0", 64'(fdata[34:0]), 64'd0);
      chk("reset_errs", 64'({ovf_err, proto_err}), 64'd0);
      rst = 1'b0;
      next_cycle();

      // 1: HEAD/BODY/TAIL to east on VC0, grant held
      h0 = mk(T_HEAD, 2'd3, 2'd1, 100);
      b0 = mk(T_BODY, 2'd0, 2'd0, 101);
      t0 = mk(T_TAIL, 2'd0, 2'd2, 102);
      drive(1'b1, 1'b0, h0, 2'b01);
      chk("t1_c0_req", 64'(req), 64'd0);
      chk("t1_c0_oack", 64'(oack), 64'd0);
      next_cycle();
      drive(1'b1, 1'b0, b0, 2'b01);
      chk("t1_c1_req_port", 64'(req_port[4:0]), 64'b00010);
      chk("t1_c1_oack", 64'(oack), 64'b01);
      chk("t1_c1_olck", 64'(olck), 64'b00);
      chk("t1_c1_fdata", 64'(fdata[34:0]), 64'(h0));
      next_cycle();
      drive(1'b1, 1'b0, t0, 2'b01);
      chk("t1_c2_req_port", 64'(req_port[4:0]), 64'b00010);
      chk("t1_c2_oack", 64'(oack), 64'b01);
      chk("t1_c2_olck", 64'(olck), 64'b01);
      chk("t1_c2_fdata", 64'(fdata[34:0]), 64'(b0));
      next_cycle();
      drive(1'b0, 1'b0, '0, 2'b01);
      chk("t1_c3_req_port", 64'(req_port[4:0]), 64'b00010);
      chk("t1_c3_oack", 64'(oack), 64'b01);
      chk("t1_c3_olck", 64'(olck), 64'b01);
      chk("t1_c3_fdata", 64'(fdata[34:0]), 64'(t0));
      next_cycle();
      drive(1'b0, 1'b0, '0, 2'b01);
      chk("t1_c4_olck", 64'(olck), 64'b00);
      chk("t1_c4_req", 64'(req), 64'b00);
      chk("t1_c4_oack", 64'(oack), 64'b00);
      next_cycle();

      // 2: SINGLE flits on VC1 to local / west / south / north
      t2x = '{2'd1, 2'd0, 2'd1, 2'd1};
      t2y = '{2'd1, 2'd1, 2'd3, 2'd0};
      t2p = '{5'b00001, 5'b00100, 5'b10000, 5'b01000};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, mk(T_SINGLE, t2x[i], t2y[i], 200 + i), 2'b00);
         next_cycle();
         drive(1'b0, 1'b0, '0, 2'b10);
         chk($sformatf("t2_req_port_%0d", i), 64'(req_port[9:5]), 64'(t2p[i]));
         chk($sformatf("t2_oack_%0d", i), 64'(oack), 64'b10);
         next_cycle();
         drive(1'b0, 1'b0, '0, 2'b00);
         chk($sformatf("t2_olck_%0d", i), 64'(olck), 64'b00);
      end
      chk("t2_req_end", 64'(req), 64'b00);

      // 3: overflow on VC0, then push with same-cycle pop on a full FIFO
      for (int i = 0; i < 6; i++) s[i] = mk(T_SINGLE, 2'd1, 2'd1, 300 + i);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, s[i], 2'b00);
         chk($sformatf("t3_ovf_pre_%0d", i), 64'(ovf_err), 64'd0);
         next_cycle();
      end
      drive(1'b1, 1'b0, s[5], 2'b01);
      chk("t3_ovf_set", 64'(ovf_err), 64'd1);
      chk("t3_front", 64'(fdata[34:0]), 64'(s[0]));
      chk("t3_full_pop_oack", 64'(oack), 64'b01);
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, '0, 2'b01);
         fd5 = (i == 3) ? s[5] : s[i+1];
         chk($sformatf("t3_drain_fdata_%0d", i), 64'(fdata[34:0]), 64'(fd5));
         chk($sformatf("t3_drain_oack_%0d", i), 64'(oack), 64'b01);
         next_cycle();
      end
      drive(1'b0, 1'b0, '0, 2'b01);
      chk("t3_drained_req", 64'(req), 64'b00);
      chk("t3_drained_oack", 64'(oack), 64'b00);
      next_cycle();

      // 4: orphan BODY on idle VC1
      drive(1'b1, 1'b1, mk(T_BODY, 2'd2, 2'd2, 400), 2'b00);
      chk("t4_proto_pre", 64'(proto_err), 64'd0);
      chk("t4_oack_write", 64'(oack), 64'b00);
      next_cycle();
      drive(1'b0, 1'b0, '0, 2'b10);
      chk("t4_oack_auto", 64'(oack), 64'b10);
      chk("t4_req_auto", 64'(req), 64'b00);
      next_cycle();
      drive(1'b0, 1'b0, '0, 2'b10);
      chk("t4_proto_set", 64'(proto_err), 64'd1);
      chk("t4_oack_after", 64'(oack), 64'b00);
      chk("t4_req_after", 64'(req), 64'b00);
      next_cycle();

      // 5: interleaved packets, VC0 east / VC1 local, alternating grants
      h0 = mk(T_HEAD, 2'd3, 2'd1, 500);
      h1 = mk(T_HEAD, 2'd1, 2'd1, 510);
      b0 = mk(T_BODY, 2'd0, 2'd0, 501);
      b1 = mk(T_BODY, 2'd0, 2'd3, 511);
      t0 = mk(T_TAIL, 2'd1, 2'd0, 502);
      t1 = mk(T_TAIL, 2'd2, 2'd1, 512);
      g5_fd = '{h0, h1, b0, b1, t0, t1};
      for (int i = 0; i < 6; i++) begin
         ch5 = 1'(i % 2);
         drive(1'b1, ch5, g5_fd[i], 2'b00);
         next_cycle();
      end
      g5_olck = '{2'b00, 2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
      g5_req  = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10};
      g5_p0   = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 1'b0, '0, (i % 2 == 0) ? 2'b01 : 2'b10);
         fd5 = (i % 2 == 0) ? fdata[34:0] : fdata[69:35];
         chk($sformatf("t5_fdata_%0d", i), 64'(fd5), 64'(g5_fd[i]));
         chk($sformatf("t5_olck_%0d", i), 64'(olck), 64'(g5_olck[i]));
         chk($sformatf("t5_req_%0d", i), 64'(req), 64'(g5_req[i]));
         chk($sformatf("t5_oack_%0d", i), 64'(oack), 64'(grant));
         chk($sformatf("t5_port0_%0d", i), 64'(req_port[4:0]), 64'(g5_p0[i]));
         chk($sformatf("t5_port1_%0d", i), 64'(req_port[9:5]), 64'b00001);
         next_cycle();
      end
      drive(1'b0, 1'b0, '0, 2'b00);
      chk("t5_end_olck", 64'(olck), 64'b00);

      // 6: reset while VC0 is mid-packet with two flits buffered
      drive(1'b1, 1'b0, mk(T_HEAD, 2'd0, 2'd1, 600), 2'b00);
      next_cycle();
      drive(1'b1, 1'b0, mk(T_BODY, 2'd0, 2'd0, 601), 2'b01);
      next_cycle();
      drive(1'b1, 1'b0, mk(T_BODY, 2'd0, 2'd0, 602), 2'b00);
      next_cycle();
      drive(1'b0, 1'b0, '0, 2'b00);
      chk("t6_pre_olck", 64'(olck), 64'b01);
      chk("t6_pre_req", 64'(req), 64'b01);
      chk("t6_pre_port", 64'(req_port[4:0]), 64'b00100);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      drive(1'b0, 1'b0, '0, 2'b11);
      chk("t6_olck", 64'(olck), 64'b00);
      chk("t6_req", 64'(req), 64'b00);
      chk("t6_oack", 64'(oack), 64'b00);
      chk("t6_fdata", 64'(fdata[34:0]), 64'd0);
      chk("t6_errs", 64'({ovf_err, proto_err}), 64'd0);
      next_cycle();
      drive(1'b0, 1'b0, '0, 2'b11);
      chk("t6_empty_oack", 64'(oack), 64'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
